// File: rtl/uart_tx.sv
// uart_tx -- serial transmitter with a one-entry holding register.
//
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Every bit lasts P clk cycles, P = prescale sampled at frame start (0 -> 1).
// A byte waiting in the holding register starts on the edge that ends the
// previous stop bit, so back-to-back frames have no idle gap.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   P_DATA       parallel byte to send
//   data_valid   P_DATA offered this cycle (taken when ready=1)
//   PAR_EN       1 adds a parity bit
//   parity_type  0 even, 1 odd
//   prescale     clk cycles per bit
//   ready        holding register empty
//   TX_OUT       registered serial line, idles high
//   busy         frame in progress
//   tx_done      one-cycle pulse after each stop bit
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  PAR_EN,
  input  logic                  parity_type,
  input  logic [5:0]            prescale,
  output logic                  ready,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_pe_q, hold_pe_d;
  logic                  hold_pt_q, hold_pt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic [5:0]            per_q, per_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic bit_end;
  logic load;

  // per_q is never 0 outside IDLE, so per_q-1 cannot underflow where it matters
  assign bit_end = (cnt_q == per_q - 6'd1);
  // Frame start: from IDLE, or straight out of the last stop cycle
  assign load    = hold_vld_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  // State register (all sequential state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_pe_q   <= 1'b0;
      hold_pt_q   <= 1'b0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      per_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_pe_q   <= hold_pe_d;
      hold_pt_q   <= hold_pt_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      per_q       <= per_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_vld_q) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_q == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = hold_vld_q ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_pe_d   = hold_pe_q;
    hold_pt_d   = hold_pt_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    per_d       = per_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;

    // load requires hold_vld_q, so it never collides with an accept
    if (load) begin
      hold_vld_d = 1'b0;
    end else if (data_valid && !hold_vld_q) begin
      hold_vld_d  = 1'b1;
      hold_data_d = P_DATA;
      hold_pe_d   = PAR_EN;
      hold_pt_d   = parity_type;
    end

    if (load) begin
      shift_d   = hold_data_q;
      par_en_d  = hold_pe_q;
      par_bit_d = (^hold_data_q) ^ hold_pt_q;
      per_d     = (prescale == 6'd0) ? 6'd1 : prescale;
      cnt_d     = '0;
      bit_d     = '0;
    end else if (state_q != IDLE) begin
      if (bit_end) begin
        cnt_d = '0;
        if (state_q == DATA) begin
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end

    // Line level follows the state being entered so TX_OUT is a plain flop
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase

    done_d = (state_q == STOP) && bit_end;
  end

  assign ready   = ~hold_vld_q;
  assign busy    = (state_q != IDLE);
  assign TX_OUT  = tx_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level model (each accepted byte expands into a
// queue of line levels, P cycles per bit) checked every cycle, plus directed
// frames with hand-computed bit patterns and lengths.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       PAR_EN;
  logic       parity_type;
  logic [5:0] prescale;
  logic       ready;
  logic       TX_OUT;
  logic       busy;
  logic       tx_done;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .data_valid(data_valid),
    .PAR_EN(PAR_EN), .parity_type(parity_type), .prescale(prescale),
    .ready(ready), .TX_OUT(TX_OUT), .busy(busy), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit         wave[$];
  logic       m_hold, m_old;
  logic [7:0] m_data;
  logic       m_pe, m_pt;
  logic       e_done;

  task automatic build_frame();
    int p;
    bit b;
    p = (prescale == 6'd0) ? 1 : int'(prescale);
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      b = 1'b0;
      else if (i <= 8) b = m_data[i-1];
      else if (i == 9) begin
        if (!m_pe) continue;
        b = (^m_data) ^ m_pt;
      end else b = 1'b1;
      for (int j = 0; j < p; j++) wave.push_back(b);
    end
  endtask

  initial begin
    m_hold = 1'b0; m_data = '0; m_pe = 1'b0; m_pt = 1'b0; e_done = 1'b0; m_old = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        wave.delete();
        m_hold = 1'b0;
        e_done = 1'b0;
      end else begin
        m_old  = m_hold;
        e_done = 1'b0;
        if (wave.size() > 0) begin
          void'(wave.pop_front());
          if (wave.size() == 0) begin
            e_done = 1'b1;
            if (m_hold) begin build_frame(); m_hold = 1'b0; end
          end
        end else if (m_hold) begin
          build_frame();
          m_hold = 1'b0;
        end
        if (data_valid && !m_old) begin
          m_hold = 1'b1; m_data = P_DATA; m_pe = PAR_EN; m_pt = parity_type;
        end
      end
      @(negedge clk);
      chk("model_tx",    TX_OUT,  (wave.size() > 0) ? wave[0] : 1'b1);
      chk("model_busy",  busy,    wave.size() > 0);
      chk("model_ready", ready,   !m_hold);
      chk("model_done",  tx_done, e_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!ready && t < 2000) begin @(posedge clk); #1; t++; end
    if (!ready) chk("send_ready_timeout", 0, 1);
    P_DATA = d; PAR_EN = pe; parity_type = pt; prescale = ps; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  // Starts at the edge after acceptance; samples first cycle of each bit
  task automatic run_frame(input string nm, input logic [11:0] bits, input int nbits,
                           input int p, input int exp_len, input int chg_at,
                           input logic [5:0] new_ps);
    int k;
    bit seen;
    k = 0; seen = 0;
    @(posedge clk);
    while (k < 3000 && !seen) begin
      @(negedge clk);
      if ((k % p) == 0 && (k / p) < nbits) chk({nm, "_bit"}, TX_OUT, bits[k/p]);
      if (k == chg_at) prescale = new_ps;
      if (tx_done) seen = 1;
      else begin @(posedge clk); k++; end
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_len"}, k, exp_len);
    @(posedge clk); @(negedge clk);
    chk({nm, "_done_pulse"}, tx_done, 0);
    chk({nm, "_idle_busy"}, busy, 0);
  endtask

  int t0, t1, ndone;
  bit seen1;

  initial begin
    rst = 1'b1; data_valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; parity_type = 1'b0;
    prescale = 6'd8;
    // byte offered during reset must be discarded
    @(posedge clk); #1; data_valid = 1'b1; P_DATA = 8'h77;
    @(posedge clk); #1; data_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", tx_done, 0);

    // even parity, 0xA5, P=8
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    run_frame("even_a5", 12'h54A, 11, 8, 88, -1, 6'd0);
    // odd parity, 0x01, P=16
    send(8'h01, 1'b1, 1'b1, 6'd16);
    run_frame("odd_01", 12'h402, 11, 16, 176, -1, 6'd0);
    // no parity, 0xFF, P=32
    send(8'hFF, 1'b0, 1'b0, 6'd32);
    run_frame("nopar_ff", 12'h3FE, 10, 32, 320, -1, 6'd0);
    // prescale 0 behaves as 1
    send(8'h96, 1'b1, 1'b0, 6'd0);
    run_frame("ps0_96", 12'h52C, 11, 1, 11, -1, 6'd0);
    // prescale change mid-frame ignored
    send(8'h5A, 1'b0, 1'b0, 6'd5);
    run_frame("pschg_5a", 12'h2B4, 10, 5, 50, 7, 6'd20);

    // back-to-back with data_valid held high
    @(posedge clk); #1;
    prescale = 6'd2; PAR_EN = 1'b0; parity_type = 1'b0; P_DATA = 8'h3C; data_valid = 1'b1;
    @(posedge clk); #1;
    P_DATA = 8'hC3;
    t0 = 0;
    while (!ready && t0 < 100) begin @(posedge clk); #1; t0++; end
    chk("b2b_ready_rise", ready, 1);
    t0 = 0;
    while (ready && t0 < 100) begin @(posedge clk); #1; t0++; end
    chk("b2b_second_taken", ready, 0);
    // ready=0: these must be ignored
    P_DATA = 8'hFF;
    repeat (4) @(posedge clk);
    #1; data_valid = 1'b0;
    t0 = 0; seen1 = 0;
    while (t0 < 200 && !seen1) begin
      @(negedge clk);
      if (tx_done) seen1 = 1; else begin @(posedge clk); t0++; end
    end
    chk("b2b_first_done", seen1, 1);
    chk("b2b_start_follows", TX_OUT, 0);
    chk("b2b_busy_kept", busy, 1);
    t1 = 0; seen1 = 0;
    @(posedge clk);
    while (t1 < 200 && !seen1) begin
      t1++;
      @(negedge clk);
      if (tx_done) seen1 = 1; else @(posedge clk);
    end
    chk("b2b_second_len", t1, 20);
    @(posedge clk); @(negedge clk);
    chk("b2b_idle", busy, 0);

    // reset during data bit 3 with a byte buffered
    send(8'h11, 1'b0, 1'b0, 6'd4);
    @(posedge clk);            // start edge S
    send(8'h22, 1'b0, 1'b0, 6'd4);
    chk("rstmid_buffered", ready, 0);
    repeat (15) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rstmid_tx", TX_OUT, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", ready, 1);
    ndone = 0;
    repeat (60) begin @(posedge clk); @(negedge clk); if (tx_done) ndone++; end
    chk("rstmid_no_done", ndone, 0);
    send(8'hA5, 1'b1, 1'b0, 6'd3);
    run_frame("after_rst", 12'h54A, 11, 3, 33, -1, 6'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, data bits per frame; the remaining requirements are stated for the default.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: P_DATA  input  8  parallel byte to transmit.
REQ-005 Port: data_valid  input  1  P_DATA is offered this cycle.
REQ-006 Port: PAR_EN  input  1  1 adds a parity bit to the frame.
REQ-007 Port: parity_type  input  1  0 gives even parity, 1 gives odd parity.
REQ-008 Port: prescale  input  6  clk cycles per bit period.
REQ-009 Port: ready  output  1  holding register empty, so the block can accept a byte.
REQ-010 Port: TX_OUT  output  1  registered serial line; idles high.
REQ-011 Port: busy  output  1  a frame is in progress (state not IDLE).
REQ-012 Port: tx_done  output  1  one-cycle pulse when a stop bit completes.

Function
REQ-013 Accept: data_valid=1 and ready=1 at a rising edge; the block SHALL capture P_DATA, PAR_EN and parity_type into a one-entry holding register.
REQ-014 When data_valid=1 and ready=0, the block SHALL ignore the input and leave the holding register unchanged.
REQ-015 ready SHALL equal NOT holding-valid, driven from a register with no combinational path from data_valid.
REQ-016 States: IDLE, START, DATA, PARITY, STOP; the block SHALL use no other states.
REQ-017 IDLE to START: holding register valid at a rising edge; that edge SHALL transfer the byte to the shifter, clear holding-valid, latch prescale, and drive TX_OUT=0.
REQ-018 Latency: a byte accepted at edge A while IDLE SHALL drive TX_OUT low from edge A+1.
REQ-019 Each bit SHALL be held for exactly P clk cycles, where P is prescale latched at frame start and 0 is treated as 1.
REQ-020 A prescale change mid-frame SHALL have no effect until the next frame start.
REQ-021 START to DATA after P cycles; DATA SHALL send 8 bits LSB first.
REQ-022 After bit 7, the next state SHALL be PARITY if the latched PAR_EN=1, otherwise STOP.
REQ-023 Parity bit SHALL equal XOR of the 8 data bits, inverted when the latched parity_type=1.
REQ-024 STOP SHALL drive TX_OUT=1 for P cycles; tx_done SHALL pulse high for one cycle on the edge that ends the stop bit.
REQ-025 At the end of STOP with holding valid, the block SHALL go directly to START on the same edge, with no idle cycle between frames.
REQ-026 At the end of STOP with holding empty, the block SHALL go to IDLE with TX_OUT=1.
REQ-027 A byte accepted during the final stop cycle SHALL be treated as holding valid at the next edge, then follow REQ-017.
REQ-028 At most one byte SHALL be buffered in addition to the frame in flight, so ready=0 while the holding register is full.
REQ-029 Frame length SHALL be (10 + PAR_EN) × P cycles, counted from the falling edge of the start bit to the end of the stop bit.
REQ-030 Bit-period counter and bit counter SHALL wrap to 0 at each bit or frame boundary, with no overflow for any 6-bit prescale.

Reset
REQ-031 When rst=1 at a rising edge, the block SHALL set TX_OUT=1, busy=0, ready=1, tx_done=0, state=IDLE, holding-valid=0 and all counters to 0.
REQ-032 rst SHALL take precedence over data_valid on the same edge; a byte offered with rst=1 SHALL be discarded.
REQ-033 rst during a frame SHALL abort it immediately with TX_OUT=1 from the next cycle, SHALL clear any buffered byte, and SHALL produce no tx_done.

Verification
REQ-034 Even parity: prescale=8, PAR_EN=1, parity_type=0, P_DATA=0xA5 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1, 8 cycles each, 88 cycles total; tx_done pulses once.
REQ-035 Odd parity: prescale=16, PAR_EN=1, parity_type=1, P_DATA=0x01 -> data bits 1,0,0,0,0,0,0,0, parity bit 0, frame of 176 cycles.
REQ-036 No parity: prescale=32, PAR_EN=0, P_DATA=0xFF -> start 0, eight 1s, stop 1, frame of 320 cycles, no parity slot.
REQ-037 Back-to-back: 0x3C then 0xC3 offered with data_valid held high -> second accepted when ready rises; second start bit directly follows the first stop bit with zero idle cycles.
REQ-038 Reset mid-frame: rst pulsed during data bit 3 -> TX_OUT=1, busy=0, ready=1 next cycle; no tx_done; the next accepted byte gets a clean frame.
REQ-039 Boundary cases: prescale=0 gives 1-cycle bits; data_valid while ready=0 is ignored; prescale changed mid-frame does not alter the current frame's bit width.
